// File: rtl/execute.sv
// ============================================================================
// execute -- RV32IM execute stage: ALU, branches/jumps, load/store, divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] instr_addr,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] r2s,
    input  logic [31:0] jmp_addr,
    input  logic [4:0]  alu_op,
    input  logic        valid,
    output logic        ready,
    output logic [4:0]  write_reg_number,
    output logic [31:0] write_reg_value,
    output logic        write_reg,
    output logic        jmp,
    output logic [31:0] jmp_target,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLT    = 5'd5;
    localparam logic [4:0] ALU_SLTU   = 5'd6;
    localparam logic [4:0] ALU_SLL    = 5'd7;
    localparam logic [4:0] ALU_SRL    = 5'd8;
    localparam logic [4:0] ALU_SRA    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_AUIPC  = 5'd11;
    localparam logic [4:0] ALU_MUL    = 5'd12;
    localparam logic [4:0] ALU_MULH   = 5'd13;
    localparam logic [4:0] ALU_MULHSU = 5'd14;
    localparam logic [4:0] ALU_MULHU  = 5'd15;
    localparam logic [4:0] ALU_DIV    = 5'd16;
    localparam logic [4:0] ALU_DIVU   = 5'd17;
    localparam logic [4:0] ALU_REM    = 5'd18;
    localparam logic [4:0] ALU_REMU   = 5'd19;
    localparam logic [4:0] ALU_JAL    = 5'd20;
    localparam logic [4:0] ALU_SEQ    = 5'd21;
    localparam logic [4:0] ALU_SNE    = 5'd22;
    localparam logic [4:0] ALU_SGE    = 5'd23;
    localparam logic [4:0] ALU_SGEU   = 5'd24;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DIV, S_WB} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic        write_reg_q, write_reg_d;
    logic [4:0]  wr_num_q, wr_num_d;
    logic [31:0] wr_val_q, wr_val_d;
    logic        jmp_q, jmp_d;
    logic [31:0] jmp_target_q, jmp_target_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_valid_q, mem_valid_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] div_rem_q, div_rem_d;
    logic [31:0] div_quo_q, div_quo_d;
    logic [31:0] div_dvs_q, div_dvs_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic        div_is_rem_q, div_is_rem_d;
    logic        div_neg_q_q, div_neg_q_d;
    logic        div_neg_r_q, div_neg_r_d;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_is_div;
    logic [31:0] w_i_imm, w_s_imm, w_b_imm, w_u_imm;
    logic        w_eq, w_lt, w_ltu, w_br_taken, w_take_jmp, w_writes_rd;
    logic [31:0] w_target, w_ls_addr, w_alu_res, w_ld_shift, w_ld_data;
    logic [63:0] w_mul_a, w_mul_b, w_mul_p;
    logic        w_div_signed, w_a_neg, w_b_neg;
    logic [32:0] w_rem_sh, w_diff;
    logic [31:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;

    assign w_opcode    = instr[6:0];
    assign w_funct3    = instr[14:12];
    assign w_rd        = instr[11:7];
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_div    = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU) ||
                         (alu_op == ALU_REM) || (alu_op == ALU_REMU);

    assign w_i_imm = {{20{instr[31]}}, instr[31:20]};
    assign w_s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_u_imm = {instr[31:12], 12'h000};

    assign w_eq  = (r1 == r2);
    assign w_lt  = ($signed(r1) < $signed(r2));
    assign w_ltu = (r1 < r2);

    // One 64-bit multiplier; operand extension selects the signedness variant.
    assign w_mul_a = {{32{(alu_op == ALU_MULH || alu_op == ALU_MULHSU) & r1[31]}}, r1};
    assign w_mul_b = {{32{(alu_op == ALU_MULH) & r2[31]}}, r2};
    assign w_mul_p = w_mul_a * w_mul_b;

    always_comb begin
        case (alu_op)
            ALU_SUB:    w_alu_res = r1 - r2;
            ALU_AND:    w_alu_res = r1 & r2;
            ALU_OR:     w_alu_res = r1 | r2;
            ALU_XOR:    w_alu_res = r1 ^ r2;
            ALU_SLT:    w_alu_res = {31'd0, w_lt};
            ALU_SLTU:   w_alu_res = {31'd0, w_ltu};
            ALU_SLL:    w_alu_res = r1 << r2[4:0];
            ALU_SRL:    w_alu_res = r1 >> r2[4:0];
            ALU_SRA:    w_alu_res = $signed(r1) >>> r2[4:0];
            ALU_LUI:    w_alu_res = w_u_imm;
            ALU_AUIPC:  w_alu_res = instr_addr + w_u_imm;
            ALU_MUL:    w_alu_res = w_mul_p[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  w_alu_res = w_mul_p[63:32];
            ALU_JAL:    w_alu_res = instr_addr + 32'd4;
            default:    w_alu_res = r1 + r2;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SEQ:  w_br_taken = w_eq;
            ALU_SNE:  w_br_taken = !w_eq;
            ALU_SLT:  w_br_taken = w_lt;
            ALU_SGE:  w_br_taken = !w_lt;
            ALU_SLTU: w_br_taken = w_ltu;
            ALU_SGEU: w_br_taken = !w_ltu;
            default:  w_br_taken = 1'b0;
        endcase
    end

    assign w_take_jmp  = w_is_jal || w_is_jalr || (w_is_branch && w_br_taken);
    assign w_target    = w_is_jal  ? jmp_addr :
                         w_is_jalr ? ((r1 + w_i_imm) & ~32'd1) :
                                     (instr_addr + w_b_imm);
    assign w_writes_rd = !w_is_branch && !w_is_store && (w_rd != 5'd0);
    assign w_ls_addr   = w_is_load ? (r1 + r2) : (r1 + w_s_imm);

    assign w_ld_shift = mem_rdata >> {mem_addr_q[1:0], 3'b000};
    always_comb begin
        case (ld_funct3_q)
            3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

    // Restoring divider step on magnitudes; signs are applied on the final step.
    assign w_div_signed = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
    assign w_a_neg      = w_div_signed & r1[31];
    assign w_b_neg      = w_div_signed & r2[31];
    assign w_rem_sh     = {div_rem_q, div_quo_q[31]};
    assign w_diff       = w_rem_sh - {1'b0, div_dvs_q};
    assign w_rem_nx     = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
    assign w_quo_nx     = {div_quo_q[30:0], !w_diff[32]};
    assign w_q_fin      = div_neg_q_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_r_fin      = div_neg_r_q ? (~w_rem_nx + 32'd1) : w_rem_nx;

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        write_reg_d  = 1'b0;
        wr_num_d     = wr_num_q;
        wr_val_d     = wr_val_q;
        jmp_d        = 1'b0;
        jmp_target_d = jmp_target_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        mem_we_d     = mem_we_q;
        mem_valid_d  = mem_valid_q;
        ld_funct3_d  = ld_funct3_q;
        pend_wr_d    = pend_wr_q;
        div_rem_d    = div_rem_q;
        div_quo_d    = div_quo_q;
        div_dvs_d    = div_dvs_q;
        div_cnt_d    = div_cnt_q;
        div_is_rem_d = div_is_rem_q;
        div_neg_q_d  = div_neg_q_q;
        div_neg_r_d  = div_neg_r_q;

        case (state_q)
            S_IDLE: begin
                // Wrong-path instructions after a redirect are silently dropped.
                if (valid && !(kill_q && (instr_addr != jmp_target_q))) begin
                    kill_d   = 1'b0;
                    wr_num_d = w_rd;
                    if (w_is_load || w_is_store) begin
                        mem_addr_d  = w_ls_addr;
                        mem_we_d    = w_is_store;
                        mem_valid_d = 1'b1;
                        ld_funct3_d = w_funct3;
                        pend_wr_d   = w_is_load && (w_rd != 5'd0);
                        case (w_funct3[1:0])
                            2'b00: begin
                                mem_be_d    = 4'b0001 << w_ls_addr[1:0];
                                mem_wdata_d = {4{r2s[7:0]}};
                            end
                            2'b01: begin
                                mem_be_d    = 4'b0011 << w_ls_addr[1:0];
                                mem_wdata_d = {2{r2s[15:0]}};
                            end
                            default: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = r2s;
                            end
                        endcase
                        state_d = S_MEM;
                    end else if (w_is_div) begin
                        div_rem_d    = 32'd0;
                        div_quo_d    = w_a_neg ? (~r1 + 32'd1) : r1;
                        div_dvs_d    = w_b_neg ? (~r2 + 32'd1) : r2;
                        div_cnt_d    = 5'd0;
                        div_is_rem_d = (alu_op == ALU_REM) || (alu_op == ALU_REMU);
                        div_neg_q_d  = (w_a_neg ^ w_b_neg) && (r2 != 32'd0);
                        div_neg_r_d  = w_a_neg;
                        pend_wr_d    = w_writes_rd;
                        state_d      = S_DIV;
                    end else begin
                        write_reg_d = w_writes_rd;
                        wr_val_d    = w_alu_res;
                        jmp_d       = w_take_jmp;
                        if (w_take_jmp) begin
                            jmp_target_d = w_target;
                        end
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    write_reg_d = pend_wr_q;
                    if (pend_wr_q) begin
                        wr_val_d = w_ld_data;
                    end
                    state_d = S_WB;
                end
            end
            S_DIV: begin
                div_rem_d = w_rem_nx;
                div_quo_d = w_quo_nx;
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) begin
                    write_reg_d = pend_wr_q;
                    wr_val_d    = div_is_rem_q ? w_r_fin : w_q_fin;
                    state_d     = S_WB;
                end
            end
            default: begin
                if (jmp_q) begin
                    kill_d = 1'b1;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            write_reg_q  <= 1'b0;
            wr_num_q     <= 5'd0;
            wr_val_q     <= 32'd0;
            jmp_q        <= 1'b0;
            jmp_target_q <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_we_q     <= 1'b0;
            mem_valid_q  <= 1'b0;
            ld_funct3_q  <= 3'd0;
            pend_wr_q    <= 1'b0;
            div_rem_q    <= 32'd0;
            div_quo_q    <= 32'd0;
            div_dvs_q    <= 32'd0;
            div_cnt_q    <= 5'd0;
            div_is_rem_q <= 1'b0;
            div_neg_q_q  <= 1'b0;
            div_neg_r_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            write_reg_q  <= write_reg_d;
            wr_num_q     <= wr_num_d;
            wr_val_q     <= wr_val_d;
            jmp_q        <= jmp_d;
            jmp_target_q <= jmp_target_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_we_q     <= mem_we_d;
            mem_valid_q  <= mem_valid_d;
            ld_funct3_q  <= ld_funct3_d;
            pend_wr_q    <= pend_wr_d;
            div_rem_q    <= div_rem_d;
            div_quo_q    <= div_quo_d;
            div_dvs_q    <= div_dvs_d;
            div_cnt_q    <= div_cnt_d;
            div_is_rem_q <= div_is_rem_d;
            div_neg_q_q  <= div_neg_q_d;
            div_neg_r_q  <= div_neg_r_d;
        end
    end

    assign ready            = (state_q == S_IDLE);
    assign stall            = (state_q != S_IDLE);
    assign write_reg        = write_reg_q;
    assign write_reg_number = wr_num_q;
    assign write_reg_value  = wr_val_q;
    assign jmp              = jmp_q;
    assign jmp_target       = jmp_target_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_be           = mem_be_q;
    assign mem_we           = mem_we_q;
    assign mem_valid        = mem_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// ============================================================================
// tb_execute -- directed self-checking bench for the execute stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_execute;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLT    = 5'd5;
    localparam logic [4:0] ALU_SLTU   = 5'd6;
    localparam logic [4:0] ALU_SLL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_AUIPC  = 5'd11;
    localparam logic [4:0] ALU_MUL    = 5'd12;
    localparam logic [4:0] ALU_MULH   = 5'd13;
    localparam logic [4:0] ALU_MULHSU = 5'd14;
    localparam logic [4:0] ALU_MULHU  = 5'd15;
    localparam logic [4:0] ALU_DIV    = 5'd16;
    localparam logic [4:0] ALU_DIVU   = 5'd17;
    localparam logic [4:0] ALU_REM    = 5'd18;
    localparam logic [4:0] ALU_REMU   = 5'd19;
    localparam logic [4:0] ALU_JAL    = 5'd20;
    localparam logic [4:0] ALU_SEQ    = 5'd21;
    localparam logic [4:0] ALU_SNE    = 5'd22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0, instr_addr = '0, r1 = '0, r2 = '0, r2s = '0, jmp_addr = '0;
    logic [4:0]  alu_op = '0;
    logic        valid = 1'b0;
    logic        ready, write_reg, jmp, stall, mem_we, mem_valid;
    logic [4:0]  write_reg_number;
    logic [31:0] write_reg_value, jmp_target, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    execute dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_addr(instr_addr), .r1(r1), .r2(r2),
        .r2s(r2s), .jmp_addr(jmp_addr), .alu_op(alu_op), .valid(valid), .ready(ready),
        .write_reg_number(write_reg_number), .write_reg_value(write_reg_value),
        .write_reg(write_reg), .jmp(jmp), .jmp_target(jmp_target), .stall(stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one instruction for a single accept cycle.
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [4:0] op,
                         input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] xs, input logic [31:0] ja);
        int w = 0;
        while (!ready && w < 100) begin
            tick();
            w++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        instr = i; instr_addr = a; alu_op = op; r1 = x1; r2 = x2; r2s = xs; jmp_addr = ja;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int  cyc = 0;
        bit  stall_ok = 1'b1;
        issue(32'h000001B3, 32'h0, op, a, b, 32'h0, 32'h0);
        while (!write_reg && cyc < 100) begin
            if (!stall) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        check({tag, "_cycles"}, 32'(cyc), 32'd32);
        check({tag, "_stall"}, 32'(stall_ok), 32'd1);
        check({tag, "_value"}, write_reg_value, exp);
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] i;
        logic [31:0] a;
        logic [4:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t alu_vecs[$] = '{
        '{32'h00000133, 32'h0,   ALU_SUB,    32'd5,        32'd7,        32'hFFFFFFFE},
        '{32'h00000133, 32'h0,   ALU_SRA,    32'h80000000, 32'h00000024, 32'hF8000000},
        '{32'h00000133, 32'h0,   ALU_SLL,    32'h00000001, 32'h00000021, 32'h00000002},
        '{32'h00000133, 32'h0,   ALU_SLTU,   32'h00000001, 32'hFFFFFFFF, 32'h00000001},
        '{32'h00000133, 32'h0,   ALU_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{32'h00000133, 32'h0,   ALU_MUL,    32'h00010000, 32'h00010000, 32'h00000000},
        '{32'h00000133, 32'h0,   ALU_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
        '{32'h00000133, 32'h0,   ALU_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001},
        '{32'h00000133, 32'h0,   ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{32'h00000133, 32'h0,   5'd31,      32'd2,        32'd3,        32'd5},
        '{32'h12345137, 32'h0,   ALU_LUI,    32'd0,        32'd0,        32'h12345000},
        '{32'h00001117, 32'h100, ALU_AUIPC,  32'd0,        32'd0,        32'h00001100}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        bit stable;
        bit saw_wr;

        // Reset values
        repeat (3) tick();
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_wr_value", write_reg_value, 32'd0);
        check("rst_jmp_target", jmp_target, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(ready), 32'd1);

        // ADDI x1,x0,5: write at N+1, ready at N+2
        issue(32'h00500093, 32'h0, ALU_ADD, 32'd0, 32'd5, 32'h0, 32'h0);
        check("addi_wr", 32'(write_reg), 32'd1);
        check("addi_num", 32'(write_reg_number), 32'd1);
        check("addi_val", write_reg_value, 32'd5);
        check("addi_stall", 32'(stall), 32'd1);
        tick();
        check("addi_ready", 32'(ready), 32'd1);
        check("addi_wr_off", 32'(write_reg), 32'd0);

        foreach (alu_vecs[k]) begin
            issue(alu_vecs[k].i, alu_vecs[k].a, alu_vecs[k].op, alu_vecs[k].x1,
                  alu_vecs[k].x2, 32'h0, 32'h0);
            check($sformatf("alu%0d_val", k), write_reg_value, alu_vecs[k].exp);
            check($sformatf("alu%0d_wr", k), 32'(write_reg), 32'd1);
        end

        // ADD x0,x1,x2 never writes
        issue(32'h00208033, 32'h0, ALU_ADD, 32'd3, 32'd4, 32'h0, 32'h0);
        check("x0_no_write", 32'(write_reg), 32'd0);

        // Divider
        run_div("div", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("rem", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("divu0", ALU_DIVU, 32'd1234, 32'd0, 32'hFFFFFFFF);
        run_div("remu0", ALU_REMU, 32'd1234, 32'd0, 32'd1234);
        run_div("div0s", ALU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        run_div("divovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("removf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_div("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);

        // LB x4,3(x1) with mem_ready on the third bus cycle
        mem_rdata = 32'h80000000;
        issue(32'h00308203, 32'h0, ALU_ADD, 32'h100, 32'd3, 32'h0, 32'h0);
        vcnt = 0;
        stable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (mem_valid) vcnt++;
            if (mem_addr !== 32'h103 || mem_be !== 4'b1000 || mem_we !== 1'b0) stable = 1'b0;
            mem_ready = (c == 2);
            tick();
        end
        mem_ready = 1'b0;
        check("lb_valid_cycles", 32'(vcnt), 32'd3);
        check("lb_bus_stable", 32'(stable), 32'd1);
        check("lb_wr", 32'(write_reg), 32'd1);
        check("lb_num", 32'(write_reg_number), 32'd4);
        check("lb_val", write_reg_value, 32'hFFFFFF80);
        check("lb_valid_drop", 32'(mem_valid), 32'd0);

        // SH at 0x202
        issue(32'h00001123, 32'h0, ALU_ADD, 32'h200, 32'd0, 32'h00001234, 32'h0);
        check("sh_addr", mem_addr, 32'h202);
        check("sh_be", 32'(mem_be), 32'b1100);
        check("sh_wdata", mem_wdata, 32'h12341234);
        check("sh_we", 32'(mem_we), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sh_no_write", 32'(write_reg), 32'd0);
        check("sh_valid_drop", 32'(mem_valid), 32'd0);

        // BEQ taken at 0x40 -> 0x50, wrong path at 0x44/0x48 dropped
        issue(32'h00000863, 32'h40, ALU_SEQ, 32'd9, 32'd9, 32'h0, 32'h0);
        check("beq_jmp", 32'(jmp), 32'd1);
        check("beq_target", jmp_target, 32'h50);
        check("beq_no_write", 32'(write_reg), 32'd0);
        tick();
        check("beq_jmp_off", 32'(jmp), 32'd0);
        issue(32'h00100293, 32'h44, ALU_ADD, 32'd0, 32'd1, 32'h0, 32'h0);
        check("kill44_wr", 32'(write_reg), 32'd0);
        check("kill44_jmp", 32'(jmp), 32'd0);
        issue(32'h0000A023, 32'h48, ALU_ADD, 32'h300, 32'd0, 32'h5, 32'h0);
        check("kill48_bus", 32'(mem_valid), 32'd0);
        issue(32'h00700313, 32'h50, ALU_ADD, 32'd0, 32'd7, 32'h0, 32'h0);
        check("tgt50_wr", 32'(write_reg), 32'd1);
        check("tgt50_num", 32'(write_reg_number), 32'd6);
        check("tgt50_val", write_reg_value, 32'd7);

        // BNE not taken, next sequential instruction executes
        issue(32'h00001863, 32'h60, ALU_SNE, 32'd1, 32'd1, 32'h0, 32'h0);
        check("bne_nt_jmp", 32'(jmp), 32'd0);
        issue(32'h00300393, 32'h64, ALU_ADD, 32'd0, 32'd3, 32'h0, 32'h0);
        check("after_bne_wr", 32'(write_reg), 32'd1);

        // JAL at 0x80 -> 0x200, then JALR to (0x300+5)&~1
        issue(32'h000000EF, 32'h80, ALU_JAL, 32'd0, 32'd0, 32'h0, 32'h200);
        check("jal_jmp", 32'(jmp), 32'd1);
        check("jal_target", jmp_target, 32'h200);
        check("jal_link", write_reg_value, 32'h84);
        issue(32'h005000E7, 32'h200, ALU_JAL, 32'h300, 32'd0, 32'h0, 32'h0);
        check("jalr_target", jmp_target, 32'h304);
        check("jalr_link", write_reg_value, 32'h204);

        // Reset on the 10th DIV cycle aborts without write-back
        issue(32'h000001B3, 32'h304, ALU_DIVU, 32'd50, 32'd5, 32'h0, 32'h0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("rstdiv_ready", 32'(ready), 32'd1);
        check("rstdiv_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        saw_wr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (write_reg) saw_wr = 1'b1;
            tick();
        end
        check("rstdiv_no_write", 32'(saw_wr), 32'd0);
        check("rstdiv_ready_after", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
